sprite_pos_scheduler: RTL and testbench
=======================================

// Module: sprite_pos_scheduler
// PURPOSE
// - Frame-synchronous controller between the CPU/game logic and the sprite renderer's position inputs.
// - Software writes sprite X/Y into shadow registers through a valid/ready port, then requests a commit.
// - The block copies all shadow positions to the live renderer registers in one cycle at the next
//   vertical-blank start, so the renderer never shows a half-updated frame (no tearing).
// - Sits between the CPU bus decode and the graphics top; runs in the 25 MHz pixel clock domain.
// PARAMETERS
// - N_SPRITES   5      number of sprite position slots
// - COORD_W     11     width of each X/Y coordinate (two's complement, matches renderer)
// - V_ACTIVE    480    pixely value at which vertical blank starts
// - HIDE_Y      11'd1023  reset Y value (off-screen); reset X = 0
// PORTS
// - clk          in   1                  pixel clock
// - rst          in   1                  synchronous active-high reset
// - wr_valid     in   1                  shadow write request
// - wr_ready     out  1                  shadow write accepted when wr_valid & wr_ready
// - wr_idx       in   $clog2(N_SPRITES)  target sprite slot
// - wr_x, wr_y   in   COORD_W            new coordinates for slot wr_idx
// - commit_req   in   1                  single-cycle pulse: commit shadow at next vblank
// - pixely       in   COORD_W            current scan line from the sync generator
// - pos_x, pos_y out  [N_SPRITES][COORD_W]  live positions driven to the renderer
// - armed        out  1                  commit pending
// - frame_done   out  1                  1-cycle pulse in the cycle live regs take new values
// - idx_err      out  1                  sticky: a write hit wr_idx >= N_SPRITES
// BEHAVIOUR
// - One clock: clk. Reset: rst, synchronous, active-high.
// - Reset: all shadow/live X = 0, Y = HIDE_Y. wr_ready = 1, armed = 0, frame_done = 0, idx_err = 0,
//   state = IDLE, vblank-edge history cleared.
// - vb_edge = (pixely == V_ACTIVE) & (pixely_q != V_ACTIVE); pixely_q is pixely registered.
// - FSM:
//   - IDLE: wr_ready = 1.
//     - commit_req & vb_edge in the same cycle -> COMMIT.
//     - commit_req alone -> ARMED.
//   - ARMED: wr_ready = 0 (shadow frozen), armed = 1, commit_req ignored; vb_edge -> COMMIT.
//   - COMMIT: wr_ready = 0. Live <= shadow for all slots in one cycle. frame_done = 1 in this
//     same cycle; the new pos_x/pos_y values are visible on the following cycle. -> IDLE.
// - Writes: an accepted write updates shadow[wr_idx] on the next edge. Live regs are untouched.
// - A write and a commit_req in the same IDLE cycle: the write is accepted and included in the commit.
// - wr_idx >= N_SPRITES: the write is accepted (handshake completes), the data is dropped and
//   idx_err is set. Only rst clears idx_err.
// - Commit latency: worst case one frame plus 2 cycles from commit_req to frame_done.
// - vb_edge is single-shot per frame; pixely wrap to 0 re-enables it.
// - rst asserted during ARMED or COMMIT: pending commit is abandoned and all regs take reset values.
// CONFIGURATION
// - SPRITE_AUTO_COMMIT_EN defined:
//   - Every vb_edge in IDLE commits (IDLE -> COMMIT); commit_req is ignored and armed stays 0.
//   - Writes arriving in the vb_edge cycle are not in that commit; they land in the next frame.
// - Not defined: a commit happens only when requested, as described above.
// STRUCTURE
// - Package sprite_pkg:
//   - typedef logic signed [COORD_W-1:0] coord_t
//   - typedef struct packed { coord_t x, y; } sprite_pos_t
//   - enum sched_state_t {IDLE, ARMED, COMMIT}
//   - constants N_SPRITES_DEF = 5, V_ACTIVE_DEF = 480
// - Sub-module vblank_edge_det: registers pixely and outputs the vb_edge pulse. Everything else
//   is flat: FSM plus shadow/live register arrays.
// TESTING
// - Reset, then sample outputs -> all pos_x = 0, all pos_y = 1023, wr_ready = 1, armed = 0, idx_err = 0.
// - Write idx2 = (100, 200) and pulse commit_req at pixely = 10 -> armed = 1; pos unchanged until
//   pixely reaches 480; frame_done pulses once; next cycle pos_x[2] = 100, pos_y[2] = 200.
// - While armed, hold wr_valid with idx0 = (5, 5) -> wr_ready = 0 until after COMMIT; the write is
//   taken in IDLE and does not appear in live regs until a second commit.
// - Same-cycle commit_req and pixely 479 -> 480 transition in IDLE -> direct COMMIT; frame_done one
//   cycle later with armed never set.
// - Write wr_idx = 6 with data (7, 7) -> handshake completes, idx_err = 1 and stays set, no slot
//   changes after commit.
// - Assert rst while ARMED, then run to pixely = 480 -> no frame_done; all positions at reset values.

Source files
------------

// File: rtl/sprite_pkg.sv
// ============================================================================
// Module : sprite_pkg
// Brief  : Shared types and defaults for the sprite position scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int COORD_W_DEF   = 11;
    localparam int N_SPRITES_DEF = 5;
    localparam int V_ACTIVE_DEF  = 480;

    typedef logic signed [COORD_W_DEF-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } sprite_pos_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/vblank_edge_det.sv
// ============================================================================
// Module : vblank_edge_det
// Brief  : Single-cycle pulse on the first line of vertical blank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vblank_edge_det #(
    parameter int COORD_W  = 11,
    parameter int V_ACTIVE = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] pixely,
    output logic               vb_edge
);

    localparam logic [COORD_W-1:0] c_v_active = COORD_W'(V_ACTIVE);

    logic [COORD_W-1:0] r_pixely_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixely_q <= '0;
        end else begin
            r_pixely_q <= pixely;
        end
    end

    // Holding pixely at V_ACTIVE produces only one pulse; leaving it re-arms.
    assign vb_edge = (pixely == c_v_active) && (r_pixely_q != c_v_active);

endmodule

`default_nettype wire

// File: rtl/sprite_pos_scheduler.sv
// ============================================================================
// Module : sprite_pos_scheduler
// Brief  : Shadow/live sprite position registers with tear-free vblank commit.
//          Option macro: SPRITE_AUTO_COMMIT_EN (commit on every vblank start).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_pos_scheduler
    import sprite_pkg::*;
#(
    parameter int                N_SPRITES = N_SPRITES_DEF,
    parameter int                COORD_W   = COORD_W_DEF,
    parameter int                V_ACTIVE  = V_ACTIVE_DEF,
    parameter logic [COORD_W-1:0] HIDE_Y   = 11'd1023
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [$clog2(N_SPRITES)-1:0]      wr_idx,
    input  logic [COORD_W-1:0]                wr_x,
    input  logic [COORD_W-1:0]                wr_y,
    input  logic                              commit_req,
    input  logic [COORD_W-1:0]                pixely,
    output logic [N_SPRITES-1:0][COORD_W-1:0] pos_x,
    output logic [N_SPRITES-1:0][COORD_W-1:0] pos_y,
    output logic                              armed,
    output logic                              frame_done,
    output logic                              idx_err
);

    localparam int c_idx_w = $clog2(N_SPRITES);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic [N_SPRITES-1:0][COORD_W-1:0] r_shadow_x;
    logic [N_SPRITES-1:0][COORD_W-1:0] r_shadow_y;
    logic [N_SPRITES-1:0][COORD_W-1:0] r_live_x;
    logic [N_SPRITES-1:0][COORD_W-1:0] r_live_y;
    logic                              r_idx_err;

    logic w_vb_edge;
    logic w_wr_ready;
    logic w_wr_fire;
    logic w_idx_ok;

    vblank_edge_det #(
        .COORD_W  (COORD_W),
        .V_ACTIVE (V_ACTIVE)
    ) u_vblank_edge_det (
        .clk     (clk),
        .rst     (rst),
        .pixely  (pixely),
        .vb_edge (w_vb_edge)
    );

    assign w_wr_fire = wr_valid && w_wr_ready;
    assign w_idx_ok  = int'(wr_idx) < N_SPRITES;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef SPRITE_AUTO_COMMIT_EN
                // Stall writes in the vblank cycle so they land in the next frame.
                w_wr_ready = !w_vb_edge;
                if (w_vb_edge) begin
                    w_state_nxt = COMMIT;
                end
`else
                w_wr_ready = 1'b1;
                if (commit_req) begin
                    w_state_nxt = w_vb_edge ? COMMIT : ARMED;
                end
`endif
            end
            ARMED: begin
                if (w_vb_edge) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx_err <= 1'b0;
            for (int i = 0; i < N_SPRITES; i++) begin
                r_shadow_x[i] <= '0;
                r_shadow_y[i] <= HIDE_Y;
                r_live_x[i]   <= '0;
                r_live_y[i]   <= HIDE_Y;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_fire) begin
                if (w_idx_ok) begin
                    for (int i = 0; i < N_SPRITES; i++) begin
                        if (wr_idx == c_idx_w'(i)) begin
                            r_shadow_x[i] <= wr_x;
                            r_shadow_y[i] <= wr_y;
                        end
                    end
                end else begin
                    r_idx_err <= 1'b1;
                end
            end
            if (r_state == COMMIT) begin
                r_live_x <= r_shadow_x;
                r_live_y <= r_shadow_y;
            end
        end
    end

    assign wr_ready   = w_wr_ready;
    assign armed      = (r_state == ARMED);
    assign frame_done = (r_state == COMMIT);
    assign idx_err    = r_idx_err;
    assign pos_x      = r_live_x;
    assign pos_y      = r_live_y;

endmodule

`default_nettype wire

// File: tb/tb_sprite_pos_scheduler.sv
// ============================================================================
// Module : tb_sprite_pos_scheduler
// Brief  : Directed self-checking bench for sprite_pos_scheduler (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sprite_pos_scheduler;

    localparam int c_n = 5;
    localparam int c_w = 11;

    logic                      clk;
    logic                      rst;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [2:0]                wr_idx;
    logic [c_w-1:0]            wr_x;
    logic [c_w-1:0]            wr_y;
    logic                      commit_req;
    logic [c_w-1:0]            pixely;
    logic [c_n-1:0][c_w-1:0]   pos_x;
    logic [c_n-1:0][c_w-1:0]   pos_y;
    logic                      armed;
    logic                      frame_done;
    logic                      idx_err;

    int n_total;
    int n_bad;

    int exp_x [c_n];
    int exp_y [c_n];

    sprite_pos_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .commit_req (commit_req),
        .pixely     (pixely),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .armed      (armed),
        .frame_done (frame_done),
        .idx_err    (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled before the next edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_pos(input string tag);
        for (int i = 0; i < c_n; i++) begin
            check_val($sformatf("%s_x%0d", tag, i), int'(pos_x[i]), exp_x[i]);
            check_val($sformatf("%s_y%0d", tag, i), int'(pos_y[i]), exp_y[i]);
        end
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_idx     = '0;
        wr_x       = '0;
        wr_y       = '0;
        commit_req = 1'b0;
        pixely     = 11'd0;
        for (int i = 0; i < c_n; i++) begin
            exp_x[i] = 0;
            exp_y[i] = 1023;
        end
        tick(3);
        rst = 1'b0;
        tick();

        // Reset state
        check_all_pos("rst");
        check_val("rst_wr_ready", int'(wr_ready), 1);
        check_val("rst_armed", int'(armed), 0);
        check_val("rst_idx_err", int'(idx_err), 0);
        check_val("rst_frame_done", int'(frame_done), 0);

        // Write slot 2 then arm a commit mid-frame
        pixely   = 11'd10;
        wr_valid = 1'b1;
        wr_idx   = 3'd2;
        wr_x     = 11'd100;
        wr_y     = 11'd200;
        check_val("w2_ready", int'(wr_ready), 1);
        tick();
        wr_valid   = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check_val("arm_armed", int'(armed), 1);
        check_val("arm_ready", int'(wr_ready), 0);
        check_val("arm_pos_x2", int'(pos_x[2]), 0);

        // Shadow frozen while armed
        wr_valid = 1'b1;
        wr_idx   = 3'd0;
        wr_x     = 11'd5;
        wr_y     = 11'd5;
        check_val("frz_ready", int'(wr_ready), 0);
        tick(3);
        check_val("frz_ready2", int'(wr_ready), 0);
        check_val("frz_pos_y2", int'(pos_y[2]), 1023);
        pixely = 11'd479;
        tick();
        check_val("pre_vb_done", int'(frame_done), 0);
        pixely = 11'd480;
        check_val("vb_done0", int'(frame_done), 0);
        tick();
        check_val("cm_done", int'(frame_done), 1);
        check_val("cm_ready", int'(wr_ready), 0);
        check_val("cm_pos_x2_old", int'(pos_x[2]), 0);
        tick();
        exp_x[2] = 100;
        exp_y[2] = 200;
        check_val("post_done", int'(frame_done), 0);
        check_val("post_ready", int'(wr_ready), 1);
        check_val("post_armed", int'(armed), 0);
        check_all_pos("c1");
        tick();
        wr_valid = 1'b0;
        tick(3);
        check_val("hold480_done", int'(frame_done), 0);
        check_val("held_wr_not_live", int'(pos_x[0]), 0);

        // Commit request coinciding with the vblank edge
        pixely = 11'd0;
        tick();
        pixely = 11'd479;
        tick();
        pixely     = 11'd480;
        commit_req = 1'b1;
        check_val("dir_armed0", int'(armed), 0);
        tick();
        commit_req = 1'b0;
        check_val("dir_done", int'(frame_done), 1);
        check_val("dir_armed1", int'(armed), 0);
        tick();
        exp_x[0] = 5;
        exp_y[0] = 5;
        check_val("dir_done_off", int'(frame_done), 0);
        check_all_pos("c2");

        // Out-of-range slot index
        pixely   = 11'd0;
        wr_valid = 1'b1;
        wr_idx   = 3'd6;
        wr_x     = 11'd7;
        wr_y     = 11'd7;
        check_val("bad_ready", int'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        check_val("bad_err", int'(idx_err), 1);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        pixely     = 11'd479;
        tick();
        pixely = 11'd480;
        tick();
        check_val("bad_cm_done", int'(frame_done), 1);
        tick();
        check_all_pos("c3");
        check_val("bad_err_sticky", int'(idx_err), 1);

        // Reset while armed abandons the commit
        pixely   = 11'd0;
        wr_valid = 1'b1;
        wr_idx   = 3'd1;
        wr_x     = 11'd9;
        wr_y     = 11'd9;
        tick();
        wr_valid   = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check_val("ra_armed", int'(armed), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("ra_armed_clr", int'(armed), 0);
        pixely = 11'd479;
        tick();
        pixely = 11'd480;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("ra_done%0d", k), int'(frame_done), 0);
        end
        for (int i = 0; i < c_n; i++) begin
            exp_x[i] = 0;
            exp_y[i] = 1023;
        end
        check_all_pos("ra");
        check_val("ra_idx_err", int'(idx_err), 0);
        check_val("ra_ready", int'(wr_ready), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
